// File: rtl/acondicionador_pkg.sv
// Shared types and helpers for the multi-channel input conditioner.
package acondicionador_pkg;

  // Edge selection shared by all channels
  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_t;

  // True when the debounced transition old_lvl -> new_lvl is one the mode asks to report
  function automatic logic edge_match(input mode_t mode, input logic old_lvl, input logic new_lvl);
    logic hit;
    hit = 1'b0;
    case (mode)
      MODE_RISE: hit = !old_lvl && new_lvl;
      MODE_FALL: hit = old_lvl && !new_lvl;
      MODE_BOTH: hit = old_lvl != new_lvl;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/acondicionador_canal.sv
// One conditioner channel: synchroniser chain, debounce counter and edge pulse.
module acondicionador_canal
  import acondicionador_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  button_i,
  input  mode_t mode_i,
  output logic  level_o,
  output logic  button_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   db;
  logic [CW-1:0]          cnt;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign level_o = db;

  // Shift the raw asynchronous input through the synchroniser flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_i};
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles, pulsing on a matching edge
  always_ff @(posedge clk) begin
    if (rst) begin
      db       <= 1'b0;
      cnt      <= '0;
      button_o <= 1'b0;
    end else begin
      button_o <= 1'b0;
      if (sync == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db       <= sync;
        cnt      <= '0;
        button_o <= edge_match(mode_i, db, sync);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/acondicionador_pulsos.sv
// Multi-channel push-button/switch conditioner: N_CH independent channels sharing one edge mode.
module acondicionador_pulsos
  import acondicionador_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button_i,
  input  logic [1:0]      mode_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] button_o
);

  mode_t mode_sel;

  assign mode_sel = mode_t'(mode_i);

  for (genvar gi = 0; gi < N_CH; gi++) begin : gen_ch
    acondicionador_canal #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_canal (
      .clk      (clk),
      .rst      (rst),
      .button_i (button_i[gi]),
      .mode_i   (mode_sel),
      .level_o  (level_o[gi]),
      .button_o (button_o[gi])
    );
  end

endmodule

// File: tb/tb_acondicionador_pulsos.sv
// Directed self-checking bench for acondicionador_pulsos with N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_acondicionador_pulsos;

  logic       clk;
  logic       rst;
  logic [1:0] button_i;
  logic [1:0] mode_i;
  logic [1:0] level_o;
  logic [1:0] button_o;

  int checks;
  int fails;

  acondicionador_pulsos #(
    .N_CH            (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .button_i (button_i),
    .mode_i   (mode_i),
    .level_o  (level_o),
    .button_o (button_o)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs forced to zero while reset is held, then the held-high input rises at edge 6
  task automatic test_reset();
    logic [1:0] exp_lvl, exp_btn;
    rst = 1'b1; button_i = 2'b01; mode_i = 2'b00;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (level_o !== 2'b00 || button_o !== 2'b00) begin
        fails++;
        $display("[TB] FAIL reset_hold edge %0d: level_o=%b button_o=%b, required 00/00", e, level_o, button_o);
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 2'b01 : 2'b00;
      exp_btn = (e == 6) ? 2'b01 : 2'b00;
      checks++;
      if (level_o !== exp_lvl) begin
        fails++;
        $display("[TB] FAIL reset_release_level edge %0d: got %b, required %b", e, level_o, exp_lvl);
      end
      checks++;
      if (button_o !== exp_btn) begin
        fails++;
        $display("[TB] FAIL reset_release_pulse edge %0d: got %b, required %b", e, button_o, exp_btn);
      end
    end
  endtask

  // A 3-cycle glitch is rejected; a stable high held 4+ cycles is accepted once
  task automatic test_glitch();
    logic [1:0] exp_lvl, exp_btn;
    mode_i = 2'b10;
    button_i = 2'b11;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) button_i = 2'b01;
      checks++;
      if (level_o !== 2'b01 || button_o !== 2'b00) begin
        fails++;
        $display("[TB] FAIL glitch_reject edge %0d: level_o=%b button_o=%b, required 01/00", e, level_o, button_o);
      end
    end
    button_i = 2'b11;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 2'b11 : 2'b01;
      exp_btn = (e == 6) ? 2'b10 : 2'b00;
      checks++;
      if (level_o !== exp_lvl || button_o !== exp_btn) begin
        fails++;
        $display("[TB] FAIL stable_accept edge %0d: level_o=%b button_o=%b, required %b/%b", e, level_o, button_o, exp_lvl, exp_btn);
      end
    end
  endtask

  // Falling-only mode: ignore falls in rise mode, ignore rise in fall mode, pulse on fall
  task automatic test_falling();
    logic [1:0] exp_lvl, exp_btn;
    mode_i = 2'b00;
    button_i = 2'b00;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 2'b00 : 2'b11;
      checks++;
      if (level_o !== exp_lvl || button_o !== 2'b00) begin
        fails++;
        $display("[TB] FAIL rise_mode_ignores_fall edge %0d: level_o=%b button_o=%b, required %b/00", e, level_o, button_o, exp_lvl);
      end
    end
    mode_i = 2'b01;
    button_i = 2'b01;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 2'b01 : 2'b00;
      checks++;
      if (level_o !== exp_lvl || button_o !== 2'b00) begin
        fails++;
        $display("[TB] FAIL fall_mode_ignores_rise edge %0d: level_o=%b button_o=%b, required %b/00", e, level_o, button_o, exp_lvl);
      end
    end
    button_i = 2'b00;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 2'b00 : 2'b01;
      exp_btn = (e == 6) ? 2'b01 : 2'b00;
      checks++;
      if (level_o !== exp_lvl || button_o !== exp_btn) begin
        fails++;
        $display("[TB] FAIL fall_pulse edge %0d: level_o=%b button_o=%b, required %b/%b", e, level_o, button_o, exp_lvl, exp_btn);
      end
    end
  endtask

  // Both-edge mode: both channels rise together, then fall together 10 cycles later
  task automatic test_back_to_back();
    logic [1:0] exp_lvl, exp_btn;
    mode_i = 2'b10;
    button_i = 2'b11;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 2'b11 : 2'b00;
      exp_btn = (e == 6) ? 2'b11 : 2'b00;
      checks++;
      if (level_o !== exp_lvl || button_o !== exp_btn) begin
        fails++;
        $display("[TB] FAIL both_rise edge %0d: level_o=%b button_o=%b, required %b/%b", e, level_o, button_o, exp_lvl, exp_btn);
      end
    end
    button_i = 2'b00;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 2'b00 : 2'b11;
      exp_btn = (e == 6) ? 2'b11 : 2'b00;
      checks++;
      if (level_o !== exp_lvl || button_o !== exp_btn) begin
        fails++;
        $display("[TB] FAIL both_fall edge %0d: level_o=%b button_o=%b, required %b/%b", e, level_o, button_o, exp_lvl, exp_btn);
      end
    end
  endtask

  // Disabled mode: level tracks with no pulses; re-enabling rise mode pulses again
  task automatic test_mode_off();
    logic [1:0] exp_lvl, exp_btn;
    mode_i = 2'b11;
    for (int phase = 0; phase < 2; phase++) begin
      button_i = (phase == 0) ? 2'b01 : 2'b00;
      for (int e = 1; e <= 9; e++) begin
        tick();
        exp_lvl = ((e >= 6) == (phase == 0)) ? 2'b01 : 2'b00;
        checks++;
        if (level_o !== exp_lvl || button_o !== 2'b00) begin
          fails++;
          $display("[TB] FAIL mode_off phase %0d edge %0d: level_o=%b button_o=%b, required %b/00", phase, e, level_o, button_o, exp_lvl);
        end
      end
    end
    mode_i = 2'b00;
    button_i = 2'b01;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 2'b01 : 2'b00;
      exp_btn = (e == 6) ? 2'b01 : 2'b00;
      checks++;
      if (level_o !== exp_lvl || button_o !== exp_btn) begin
        fails++;
        $display("[TB] FAIL mode_reenable edge %0d: level_o=%b button_o=%b, required %b/%b", e, level_o, button_o, exp_lvl, exp_btn);
      end
    end
  endtask

  // Reset pulse during a partial debounce discards the count; counting restarts after release
  task automatic test_reset_mid_debounce();
    logic [1:0] exp_lvl, exp_btn;
    mode_i = 2'b00;
    button_i = 2'b00;
    for (int e = 1; e <= 9; e++) tick();
    checks++;
    if (level_o !== 2'b00 || button_o !== 2'b00) begin
      fails++;
      $display("[TB] FAIL mid_reset_setup: level_o=%b button_o=%b, required 00/00", level_o, button_o);
    end
    button_i = 2'b01;
    for (int e = 1; e <= 4; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (level_o !== 2'b00 || button_o !== 2'b00) begin
      fails++;
      $display("[TB] FAIL mid_reset_clear: level_o=%b button_o=%b, required 00/00", level_o, button_o);
    end
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp_lvl = (e >= 6) ? 2'b01 : 2'b00;
      exp_btn = (e == 6) ? 2'b01 : 2'b00;
      checks++;
      if (level_o !== exp_lvl || button_o !== exp_btn) begin
        fails++;
        $display("[TB] FAIL mid_reset_restart edge %0d: level_o=%b button_o=%b, required %b/%b", e, level_o, button_o, exp_lvl, exp_btn);
      end
    end
  endtask

  // Run every scenario in order and report
  initial begin
    checks = 0;
    fails = 0;
    rst = 1'b1;
    button_i = 2'b00;
    mode_i = 2'b00;
    test_reset();
    test_glitch();
    test_falling();
    test_back_to_back();
    test_mode_off();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/acondicionador_pulsos.md
# acondicionador_pulsos

Parametrised multi-channel input conditioner for push-buttons and switches. Each channel is synchronised, debounced and edge-detected; the block outputs the clean level plus a one-clock pulse on the selected edge type. Sits between the board pins and the control FSMs and replaces per-button single-channel edge detectors.

## Interface

Parameters:
- `N_CH`, 4, number of independent channels (≥1)
- `SYNC_STAGES`, 2, synchroniser flop depth (≥2)
- `DEBOUNCE_CYCLES`, 16, consecutive disagreeing cycles before the debounced level changes (≥1)

Ports:
- `clk`  in  1  single clock for all logic
- `rst`  in  1  synchronous, active-high reset
- `button_i`  in  N_CH  raw asynchronous inputs
- `mode_i`  in  2  edge select shared by all channels: 00 rising, 01 falling, 10 both, 11 pulses disabled
- `level_o`  out  N_CH  debounced level per channel
- `button_o`  out  N_CH  one-cycle pulse per channel on the selected edge of `level_o`

## Operation

- Per channel, three stages: synchroniser chain → debounce counter → edge detector.
- Synchroniser: `SYNC_STAGES` flops in series; the last stage is `sync`.
- Debounce: registered level `db` and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `sync == db`, then `cnt <= 0`.
  - Else, if `cnt == DEBOUNCE_CYCLES-1`, then `db <= sync` and `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
- A disagreement shorter than `DEBOUNCE_CYCLES` consecutive cycles clears `cnt` and leaves `db` unchanged. The counter never wraps.
- `level_o` is `db`.
- Edge: `button_o[i]` is registered. It is 1 in exactly the cycle where `level_o[i]` first shows its new value, and only if the transition matches `mode_i` sampled on that same update edge.
- Mode 11: `button_o` is held at 0; `level_o` still tracks.
- A `mode_i` change affects only updates that occur after the change. In-flight debounce state is not disturbed.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.

## Timing

- Reset: all synchroniser flops, `db`, `cnt`, `level_o` and `button_o` are 0 while `rst` is high. `rst` overrides every other update.
- Input held high through reset: this is treated as a rising transition after release. It produces a pulse in mode 00 or 10.
- Latency: `button_i` changes before edge 1 and stays stable. Then `level_o` and `button_o` update at edge `SYNC_STAGES + DEBOUNCE_CYCLES` (default 18).
- `button_o` width: exactly one cycle per accepted transition, never back-to-back on one channel. The minimum spacing between accepted transitions is `DEBOUNCE_CYCLES` cycles.
- Reset mid-debounce: the partial count is discarded. After release, counting restarts from 0.
- `DEBOUNCE_CYCLES = 1`: `db` follows `sync` with one cycle of delay.

## Structure

- Package `acondicionador_pkg`:
  - `typedef enum logic [1:0] mode_t {MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_OFF=2'b11}`
  - Helper function `edge_match(mode_t, logic old_lvl, logic new_lvl)`
- Sub-module `acondicionador_canal`: one channel (synchroniser, debounce, edge). It takes `SYNC_STAGES` and `DEBOUNCE_CYCLES` as parameters and is instantiated `N_CH` times in a generate loop.
- Top level: only the generate loop and port fan-out.

## Test plan

All scenarios use `N_CH=2`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`.

1. Reset held 3 cycles with `button_i=2'b01`, mode 00.
   - All outputs 0 during reset.
   - After the first edge with `rst=0`, `level_o[0]=1` and `button_o[0]=1` for one cycle at edge 6.
   - Channel 1 stays 0.
2. 3-cycle high glitch on `button_i[1]`, mode 10 → `level_o` and `button_o` remain 0 throughout. A following 4-cycle-stable high is accepted and pulses once.
3. Mode 01, `button_i[0]` 1→0 after settling high → a single pulse 6 cycles after the fall, none on the earlier rise.
4. Mode 10, both channels toggle on the same cycle, rise then fall 10 cycles later → two simultaneous pulse pairs. Each pulse is exactly 1 cycle wide.
5. Mode 11, channel 0 toggled → `level_o[0]` follows with 6-cycle latency, `button_o` stays 2'b00. Switching to mode 00 before the next rise yields a pulse.
6. `rst` asserted for 1 cycle while channel 0 `cnt=2` → counter cleared, `level_o` 0. The input, still high, yields `level_o[0]=1` at edge 6 after release.
